// File: rtl/ebr_pkg.sv
// Shared definitions for the EBR stream reader.
//   state_e          : sequencer states (idle, issuing, draining, completion pulse)
//   FIFO_DEPTH       : output FIFO depth; also the credit limit for outstanding reads
//   LAT_NOREG/OUTREG : EBR read latency for each REGMODE setting
//   regmode_lat()    : maps a REGMODE string to its read latency
package ebr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } state_e;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LAT_NOREG  = 1;
    localparam int unsigned LAT_OUTREG = 2;

    function automatic int unsigned regmode_lat(input string mode);
        return (mode == "OUTREG") ? LAT_OUTREG : LAT_NOREG;
    endfunction

endpackage

// File: rtl/ebr_rd_fifo.sv
// 4-entry first-word-fallthrough FIFO holding EBR read words plus their last-word tag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data,
//   push_last           : write strobe, data word and its last tag
//   pop                 : consume the head entry (ignored when empty)
//   dout, dlast, valid  : head entry, visible straight from the storage registers
//   count               : number of stored entries (0..FIFO_DEPTH)
module ebr_rd_fifo
    import ebr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [DATA_WIDTH-1:0]           push_data,
    input  logic                            push_last,
    input  logic                            pop,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            dlast,
    output logic                            valid,
    output logic [$clog2(FIFO_DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic                 do_pop;

    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {push_last, push_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign {dlast, dout} = mem_q[rd_ptr_q];
    assign valid         = (count_q != '0);
    assign count         = count_q;

    // The reader's credit scheme must never let a push land on a full FIFO.
    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !do_pop && (count_q == FULL)));

endmodule

// File: rtl/ebr_stream_reader.sv
// Read-side sequencer for a single-port EBR: issues LEN consecutive reads from BASE_AD,
// absorbs the fixed read latency and streams the words out on a valid/ready interface.
//   CLK, RST            : clock, asynchronous active-low reset
//   START, BASE_AD, LEN : transfer request and its parameters (captured only in idle)
//   BUSY, DONE          : transfer in progress / one-cycle completion pulse
//   MEM_CE, MEM_WE,
//   MEM_CS, MEM_AD      : EBR control and address
//   MEM_DO              : EBR read data
//   DOUT, DVALID,
//   DREADY, DLAST       : output stream, DLAST marks the final word
module ebr_stream_reader
    import ebr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned ADDR_WIDTH = 13,
    parameter string       REGMODE    = "NOREG",
    parameter logic [2:0]  CSDECODE   = 3'b000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [ADDR_WIDTH-1:0]   BASE_AD,
    input  logic [ADDR_WIDTH:0]     LEN,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    MEM_CE,
    output logic                    MEM_WE,
    output logic [2:0]              MEM_CS,
    output logic [ADDR_WIDTH-1:0]   MEM_AD,
    input  logic [DATA_WIDTH-1:0]   MEM_DO,
    output logic [DATA_WIDTH-1:0]   DOUT,
    output logic                    DVALID,
    input  logic                    DREADY,
    output logic                    DLAST
);

    localparam int unsigned LAT   = regmode_lat(REGMODE);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  last_ad_q;
    logic [ADDR_WIDTH:0]    rem_q;
    // One bit per pipeline stage: a read is in flight, and whether it is the final one.
    logic [LAT-1:0]         vld_sr_q;
    logic [LAT-1:0]         tag_sr_q;

    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       inflight;
    logic                   issue;
    logic                   is_last_issue;
    logic                   capture;
    logic                   fifo_valid;
    logic                   fifo_last;
    logic [DATA_WIDTH-1:0]  fifo_dout;
    logic                   last_hs;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            inflight = inflight + CNT_W'(vld_sr_q[i]);
        end
    end

    // Every issued read is guaranteed a FIFO slot when its data returns.
    assign issue         = (state_q == StRun) &&
                           ((inflight + fifo_count) < CNT_W'(FIFO_DEPTH));
    assign is_last_issue = issue && (rem_q == (ADDR_WIDTH + 1)'(1));
    assign capture       = (state_q == StIdle) && START;
    assign last_hs       = fifo_valid && fifo_last && DREADY;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (START) state_d = (LEN == '0) ? StFin : StRun;
            StRun:   if (is_last_issue) state_d = StDrain;
            StDrain: if (last_hs) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            last_ad_q <= '0;
            rem_q     <= '0;
            vld_sr_q  <= '0;
            tag_sr_q  <= '0;
        end else begin
            state_q     <= state_d;
            vld_sr_q[0] <= issue;
            tag_sr_q[0] <= is_last_issue;
            for (int unsigned i = 1; i < LAT; i++) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
                tag_sr_q[i] <= tag_sr_q[i-1];
            end
            if (capture) begin
                addr_q <= BASE_AD;
                rem_q  <= LEN;
            end else if (issue) begin
                addr_q    <= addr_q + 1'b1;
                rem_q     <= rem_q - 1'b1;
                last_ad_q <= addr_q;
            end
        end
    end

    ebr_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (vld_sr_q[LAT-1]),
        .push_data (MEM_DO),
        .push_last (tag_sr_q[LAT-1]),
        .pop       (DREADY),
        .dout      (fifo_dout),
        .dlast     (fifo_last),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign BUSY   = (state_q != StIdle);
    assign DONE   = (state_q == StFin);
    assign MEM_CE = issue;
    assign MEM_WE = 1'b0;
    assign MEM_CS = CSDECODE;
    // Address holds the last issued value between issues.
    assign MEM_AD = issue ? addr_q : last_ad_q;
    assign DOUT   = fifo_dout;
    assign DVALID = fifo_valid;
    assign DLAST  = fifo_valid && fifo_last;

endmodule

// File: doc/ebr_stream_reader.md
Name: ebr_stream_reader

Overview:
- Read-side sequencer for a single-port 8 Kbit EBR instance.
- On START it issues LEN consecutive read addresses from BASE_AD and absorbs the fixed EBR read latency (REGMODE-dependent).
- It presents the words on a valid/ready stream with DLAST on the final word.
- It sits between the EBR and any consumer that can apply backpressure (UART/packet transmitters, DMA).

Parameters:
- DATA_WIDTH, 18, stream and EBR data width (1..18).
- ADDR_WIDTH, 13, EBR address width; addresses wrap modulo 2^ADDR_WIDTH.
- REGMODE, "NOREG", must match the EBR setting; "NOREG" gives read latency LAT=1, "OUTREG" gives LAT=2.
- CSDECODE, 3'b000, value driven on MEM_CS so the EBR is always selected.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- BASE_AD  in  ADDR_WIDTH  first read address; captured with START.
- LEN  in  ADDR_WIDTH+1  word count (0..2^ADDR_WIDTH); captured with START.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse when the transfer completes.
- MEM_CE  out  1  EBR clock enable; high only on issue cycles.
- MEM_WE  out  1  constant 0.
- MEM_CS  out  3  constant CSDECODE.
- MEM_AD  out  ADDR_WIDTH  EBR address.
- MEM_DO  in  DATA_WIDTH  EBR read data.
- DOUT  out  DATA_WIDTH  stream data.
- DVALID  out  1  stream valid.
- DREADY  in  1  stream ready.
- DLAST  out  1  marks the final word; qualified by DVALID.

Behaviour:
- Reset (RST low, async): state=IDLE, FIFO empty, in-flight pipeline cleared. BUSY=0, DONE=0, MEM_CE=0, MEM_AD=0, DVALID=0, DLAST=0, DOUT=0. MEM_WE=0 and MEM_CS=CSDECODE at all times.
- States:
  - IDLE -> RUN on START with LEN!=0.
  - IDLE -> FIN on START with LEN==0.
  - RUN -> DRAIN after the last address is issued.
  - DRAIN -> FIN when the last word is handshaked (DVALID&DREADY&DLAST).
  - FIN -> IDLE unconditionally.
- DONE=1 only in FIN. BUSY=1 in RUN, DRAIN and FIN.
- LEN==0 gives BUSY and DONE high for one cycle and no MEM_CE.
- START while not IDLE is ignored; BASE_AD and LEN are not recaptured.
- Issue rule, evaluated each cycle in RUN:
  - issue (MEM_CE=1, MEM_AD=current address) iff inflight+fifo_count < 4.
  - inflight = issues still inside the LAT-deep valid shift register.
  - After each issue: address increments with wrap (2^ADDR_WIDTH-1 -> 0) and the remaining count decrements.
- MEM_AD holds its last value when MEM_CE=0.
- Latency: data for an issue at cycle t is on MEM_DO in cycle t+LAT. It is written to the FIFO at the end of cycle t+LAT and visible on DOUT at t+LAT+1.
- With START at cycle 0 and DREADY high:
  - first MEM_CE at cycle 1;
  - first DVALID at cycle 3 (NOREG) or cycle 4 (OUTREG);
  - one word per cycle thereafter.
- FIFO: 4 entries, first-word-fallthrough register output. Simultaneous push and pop leaves the count unchanged. The credit rule guarantees no overflow; overflow is an assertion failure.
- DVALID stays high and DOUT/DLAST stay stable until DREADY; standard valid/ready rules.
- DLAST travels with the data as a tag bit set on the final issue.
- Words are emitted in address order, never duplicated or dropped.
- Deasserting DREADY stalls issue within one cycle of the FIFO reaching 4 minus inflight. MEM_DO is never sampled without a matching issue.

Decomposition:
- Shared package ebr_pkg:
  - state enum (IDLE/RUN/DRAIN/FIN);
  - constants FIFO_DEPTH=4, LAT_NOREG=1, LAT_OUTREG=2;
  - function mapping a REGMODE string to LAT.
- One sub-module, ebr_rd_fifo: 4-entry FWFT FIFO with data+last bits, count output and async active-low reset.
- Address/count/credit logic stays in the top level.

Test Plan:
- NOREG, BASE_AD=0x010, LEN=5, DREADY=1, memory preloaded mem[a]=a^0x2AAAA&0x3FFFF -> MEM_CE cycles 1-5, DVALID cycles 3-7 with words for 0x010..0x014, DLAST at cycle 7, DONE pulse at cycle 8, BUSY cycles 1-8.
- OUTREG, same stimulus -> DVALID cycles 4-8, data identical, DONE at cycle 9.
- BASE_AD=0x1FFE, LEN=4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 in order, no extra MEM_CE.
- LEN=16, DREADY low for 10 cycles then toggling 1010... -> outstanding+fifo never exceeds 4, all 16 words in order, DOUT stable while stalled, no drop or duplicate.
- LEN=0 -> BUSY and DONE high for exactly one cycle, MEM_CE never high. A second START while BUSY in a LEN=8 run is ignored (exactly 8 words).
- RST low mid-transfer after 3 words in a LEN=10 run -> all outputs at reset values asynchronously. A following START, BASE_AD=0x000, LEN=2, yields only 2 fresh words with no stale data.
